// File: rtl/grid_memory_arb_pkg.sv
// rtl/grid_memory_arb_pkg.sv - shared types and helpers for grid_memory_arbiter
// Optional write forwarding: GRID_MEMORY_ARB_WR_FWD_EN adds fwd flag and data to each tag entry.
package grid_memory_arb_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int NUM_REQ_MAX = 8;
    localparam int IDX_W       = 3;
    localparam int DATA_W_MAX  = 32;

    typedef struct packed {
        logic                   valid;
        logic [NUM_REQ_MAX-1:0] tag;
`ifdef GRID_MEMORY_ARB_WR_FWD_EN
        logic                   fwd;
        logic [DATA_W_MAX-1:0]  fdata;
`endif
    } tag_entry_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ_MAX-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/grid_memory_rr_arbiter.sv
// rtl/grid_memory_rr_arbiter.sv - round-robin arbiter, search starts one past the last grant
module grid_memory_rr_arbiter
    import grid_memory_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     cand,
    input  logic             adv,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0]       ptr;
    logic [NUM_REQ_MAX-1:0] grant_wide;

    always_comb begin
        logic found;
        int   j;
        grant      = '0;
        found      = 1'b0;
        j          = 0;
        grant_wide = '0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && cand[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
        grant_wide[N-1:0] = grant;
        idx = onehot_to_idx(grant_wide);
    end

    // Pointer moves only when something was granted; idle cycles keep the fairness position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDX_W'(N - 1);
        end else if (adv && |cand) begin
            ptr <= idx;
        end
    end

endmodule

// File: rtl/grid_memory_arbiter.sv
// rtl/grid_memory_arbiter.sv - shares one 1W/1R memory tile between NUM_REQ requesters
// Optional: GRID_MEMORY_ARB_WR_FWD_EN forwards same-cycle write data to a same-address read.
module grid_memory_arbiter
    import grid_memory_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_waddr,
    output logic [ADDR_W-1:0]         mem_raddr,
    output logic [DATA_W-1:0]         mem_data_in,
    output logic                      mem_wen,
    output logic                      mem_ren,
    input  logic [DATA_W-1:0]         mem_data_out
);

    logic [NUM_REQ-1:0] wr_cand, rd_raw, rd_cand, hazard, wr_grant, rd_grant;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic [ADDR_W-1:0]  wr_addr_sel, rd_addr_sel;
    logic [DATA_W-1:0]  wr_data_sel;

    // Candidates are gated by reset so every combinational output reads 0 while reset is held.
    assign wr_cand = reset ? '0 : (req_valid & req_we);
    assign rd_raw  = reset ? '0 : (req_valid & ~req_we);

    grid_memory_rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk   (clk),
        .rst   (reset),
        .cand  (wr_cand),
        .adv   (1'b1),
        .grant (wr_grant),
        .idx   (wr_idx)
    );

    always_comb begin
        wr_addr_sel = req_addr[int'(wr_idx)*ADDR_W +: ADDR_W];
        wr_data_sel = req_wdata[int'(wr_idx)*DATA_W +: DATA_W];
        for (int i = 0; i < NUM_REQ; i++) begin
            hazard[i] = (|wr_grant) && (req_addr[i*ADDR_W +: ADDR_W] == wr_addr_sel);
        end
    end

`ifdef GRID_MEMORY_ARB_WR_FWD_EN
    assign rd_cand = rd_raw;
`else
    assign rd_cand = rd_raw & ~hazard;
`endif

    grid_memory_rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk   (clk),
        .rst   (reset),
        .cand  (rd_cand),
        .adv   (1'b1),
        .grant (rd_grant),
        .idx   (rd_idx)
    );

    assign rd_addr_sel = req_addr[int'(rd_idx)*ADDR_W +: ADDR_W];
    assign mem_wen     = |wr_grant;
    assign mem_ren     = |rd_grant;
    assign mem_waddr   = mem_wen ? wr_addr_sel : '0;
    assign mem_data_in = mem_wen ? wr_data_sel : '0;
    assign mem_raddr   = mem_ren ? rd_addr_sel : '0;
    assign req_ready   = wr_grant | rd_grant;

    tag_entry_t pipe [READ_LAT];
    tag_entry_t pipe_in;
    tag_entry_t pipe_out;

    always_comb begin
        pipe_in                 = '0;
        pipe_in.valid           = |rd_grant;
        pipe_in.tag[NUM_REQ-1:0] = rd_grant;
`ifdef GRID_MEMORY_ARB_WR_FWD_EN
        pipe_in.fwd                = |(rd_grant & hazard);
        pipe_in.fdata[DATA_W-1:0]  = wr_data_sel;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= pipe_in;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign pipe_out = pipe[READ_LAT-1];

    always_comb begin
        rsp_valid = pipe_out.valid ? pipe_out.tag[NUM_REQ-1:0] : '0;
        rsp_rdata = '0;
        if (pipe_out.valid) begin
            rsp_rdata = mem_data_out;
`ifdef GRID_MEMORY_ARB_WR_FWD_EN
            if (pipe_out.fwd) begin
                rsp_rdata = pipe_out.fdata[DATA_W-1:0];
            end
`endif
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pipe_out};

endmodule

// File: tb/tb_grid_memory_arbiter.sv
// tb/tb_grid_memory_arbiter.sv - directed self-checking bench for grid_memory_arbiter (READ_LAT=2)
module tb_grid_memory_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int RL = 2;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req_valid, req_we, req_ready, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_rdata, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic          mem_wen, mem_ren;

    int tests  = 0;
    int failed = 0;

    grid_memory_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_waddr    (mem_waddr),
        .mem_raddr    (mem_raddr),
        .mem_data_in  (mem_data_in),
        .mem_wen      (mem_wen),
        .mem_ren      (mem_ren),
        .mem_data_out (mem_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory tile model: read-before-write array with a RL-stage read pipe.
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rd0, rd1;
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rd0 = '0;
        rd1 = '0;
    end
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_data_in;
        rd0 <= mem_ren ? mem[mem_raddr] : '0;
        rd1 <= rd0;
    end
    assign mem_data_out = rd1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]            = v;
        req_we[i]               = we;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(16 + i), DW'(32 + i));
        #2;
        tests++; if (req_ready !== 4'b0000) begin failed++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        tests++; if (mem_wen !== 1'b0 || mem_ren !== 1'b0) begin failed++; $display("FAIL rst_en: got wen=%b ren=%b want 0 0", mem_wen, mem_ren); end
        tests++; if (mem_waddr !== '0 || mem_raddr !== '0 || mem_data_in !== '0) begin failed++; $display("FAIL rst_mem: got %h %h %h want 0", mem_waddr, mem_raddr, mem_data_in); end
        tests++; if (rsp_valid !== 4'b0000 || rsp_rdata !== 8'h00) begin failed++; $display("FAIL rst_rsp: got %b %h want 0000 00", rsp_valid, rsp_rdata); end
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_rr_writes();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            tests++; if (req_ready !== 4'(1 << exp_g[k])) begin failed++; $display("FAIL rr_wr_grant[%0d]: got %b want %b", k, req_ready, 4'(1 << exp_g[k])); end
            tests++; if (mem_wen !== 1'b1 || mem_waddr !== AW'(16 + exp_g[k]) || mem_data_in !== DW'(32 + exp_g[k])) begin
                failed++; $display("FAIL rr_wr_mem[%0d]: got wen=%b addr=%h data=%h want 1 %h %h", k, mem_wen, mem_waddr, mem_data_in, AW'(16 + exp_g[k]), DW'(32 + exp_g[k]));
            end
            cyc();
        end
        clear_reqs();
        cyc();
    endtask

    task automatic test_hazard();
        set_req(0, 1'b1, 1'b1, 10'h3FF, 8'hA5);
        set_req(1, 1'b1, 1'b0, 10'h3FF, 8'h00);
        #1;
`ifdef GRID_MEMORY_ARB_WR_FWD_EN
        tests++; if (req_ready !== 4'b0011 || mem_ren !== 1'b1) begin failed++; $display("FAIL hz_fwd_grant: got %b ren=%b want 0011 1", req_ready, mem_ren); end
        cyc();
        clear_reqs();
`else
        tests++; if (req_ready !== 4'b0001 || mem_ren !== 1'b0) begin failed++; $display("FAIL hz_stall: got %b ren=%b want 0001 0", req_ready, mem_ren); end
        cyc();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        tests++; if (req_ready !== 4'b0010 || mem_ren !== 1'b1 || mem_raddr !== 10'h3FF) begin failed++; $display("FAIL hz_late_grant: got %b ren=%b raddr=%h want 0010 1 3ff", req_ready, mem_ren, mem_raddr); end
        cyc();
        clear_reqs();
`endif
        tests++; if (rsp_valid !== 4'b0000) begin failed++; $display("FAIL hz_early_rsp: got %b want 0000", rsp_valid); end
        cyc();
        tests++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 8'hA5) begin failed++; $display("FAIL hz_rsp: got %b %h want 0010 a5", rsp_valid, rsp_rdata); end
        cyc();
    endtask

    task automatic test_parallel();
        set_req(0, 1'b1, 1'b1, 10'h005, 8'h77);
        cyc();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(2, 1'b1, 1'b0, 10'h005, 8'h00);
        set_req(3, 1'b1, 1'b1, 10'h006, 8'h5A);
        #1;
        tests++; if (req_ready !== 4'b1100 || mem_wen !== 1'b1 || mem_ren !== 1'b1) begin failed++; $display("FAIL par_grant: got %b wen=%b ren=%b want 1100 1 1", req_ready, mem_wen, mem_ren); end
        tests++; if (mem_waddr !== 10'h006 || mem_raddr !== 10'h005) begin failed++; $display("FAIL par_addr: got w=%h r=%h want 006 005", mem_waddr, mem_raddr); end
        cyc();
        clear_reqs();
        cyc();
        tests++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'h77) begin failed++; $display("FAIL par_rsp: got %b %h want 0100 77", rsp_valid, rsp_rdata); end
        cyc();
    endtask

    task automatic test_back_to_back();
        set_req(0, 1'b1, 1'b0, 10'h010, 8'h00);
        set_req(1, 1'b1, 1'b0, 10'h011, 8'h00);
        #1;
        tests++; if (req_ready !== 4'b0001) begin failed++; $display("FAIL b2b_g0: got %b want 0001", req_ready); end
        cyc();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        tests++; if (req_ready !== 4'b0010) begin failed++; $display("FAIL b2b_g1: got %b want 0010", req_ready); end
        cyc();
        clear_reqs();
        #1;
        tests++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 8'h20) begin failed++; $display("FAIL b2b_rsp0: got %b %h want 0001 20", rsp_valid, rsp_rdata); end
        cyc();
        tests++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 8'h21) begin failed++; $display("FAIL b2b_rsp1: got %b %h want 0010 21", rsp_valid, rsp_rdata); end
        cyc();
        tests++; if (rsp_valid !== 4'b0000 || rsp_rdata !== 8'h00) begin failed++; $display("FAIL b2b_idle: got %b %h want 0000 00", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_starvation();
        int exp_g [4] = '{2, 3, 0, 1};
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(16 + i), 8'h00);
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (req_ready !== 4'(1 << exp_g[k])) begin failed++; $display("FAIL starve_grant[%0d]: got %b want %b", k, req_ready, 4'(1 << exp_g[k])); end
            cyc();
        end
        clear_reqs();
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 1'b0, 10'h010, 8'h00);
        #1;
        tests++; if (req_ready !== 4'b0001) begin failed++; $display("FAIL rmid_grant: got %b want 0001", req_ready); end
        cyc();
        reset = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0000 || mem_ren !== 1'b0 || rsp_valid !== 4'b0000) begin failed++; $display("FAIL rmid_outs: got ready=%b ren=%b rsp=%b want 0", req_ready, mem_ren, rsp_valid); end
        clear_reqs();
        cyc();
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (rsp_valid !== 4'b0000) begin failed++; $display("FAIL rmid_norsp[%0d]: got %b want 0000", k, rsp_valid); end
            cyc();
        end
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(16 + i), DW'(32 + i));
        #1;
        tests++; if (req_ready !== 4'b0001) begin failed++; $display("FAIL rmid_first: got %b want 0001", req_ready); end
        cyc();
        clear_reqs();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_rr_writes();
        test_hazard();
        test_parallel();
        test_back_to_back();
        test_starvation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
